usb_image_loader: RTL and testbench
===================================

// Module: usb_image_loader
// PURPOSE
//  Frames the inbound USB byte stream into complete 28x28 MNIST images ahead of the CNN core.
//  Double-buffers frames (ping-pong) so the next image is received while the core reads the current one.
//  Presents a registered random-access pixel read port, plus per-frame mode (train/infer) and label.
// PARAMETERS
//  NUM_PIXELS  784   pixels per frame (28x28)
//  ADDR_W      10    pixel address width; must satisfy 2**ADDR_W >= NUM_PIXELS
//  SYNC_BYTE   8'hA5 frame start marker
// PORTS
//  clk               in   1       system clock
//  rst               in   1       synchronous reset, active-low
//  usb_data_in       in   8       inbound USB byte
//  usb_data_valid    in   1       usb_data_in valid this cycle
//  usb_data_accept   out  1       loader takes byte; transfer = valid && accept
//  frame_valid       out  1       a complete frame is readable
//  frame_mode_train  out  1       mode of readable frame (1=train); meaningful while frame_valid
//  frame_label       out  4       training label of readable frame (0 for inference)
//  rd_addr           in   ADDR_W  pixel index for core reads
//  rd_data           out  8       pixel at rd_addr, 1-cycle latency
//  frame_release     in   1       1-cycle pulse: core finished with frame; ignored if !frame_valid
//  err_flags         out  2       sticky: [0] bad header/label, [1] checksum fail
//  err_clr           in   1       clears err_flags
// BEHAVIOUR
//  Reset (rst==0 at clk edge): FSM->IDLE, both bank-full flags=0, wr_sel=rd_sel=0, err_flags=0,
//   frame_valid=0, frame_mode_train=0, frame_label=0, rd_data=0. Any partial frame is discarded.
//  Wire format: SYNC_BYTE, MODE (8'h00 infer / 8'h01 train), LABEL (train only, 0..9),
//   NUM_PIXELS pixel bytes, [CHK if LOADER_CHECKSUM_EN].
//  FSM: IDLE -> MODE on SYNC_BYTE; non-sync bytes in IDLE are consumed and dropped.
//   MODE: 00 -> PIX; 01 -> LABEL; other value -> set err[0], go to IDLE.
//   LABEL: value <=9 -> PIX; >9 -> set err[0], go to IDLE.
//   PIX: write byte to {wr_sel,pix_cnt}; pix_cnt++; at count NUM_PIXELS-1 -> CHK or COMMIT.
//   COMMIT (internal, no byte consumed): full[wr_sel]=1, latch mode/label into bank meta, wr_sel^=1, -> IDLE.
//  usb_data_accept = 1 in MODE/LABEL/PIX/CHK; in IDLE only when full[wr_sel]==0; 0 in COMMIT.
//   Backpressure: both banks full -> accept held low in IDLE, no bytes lost.
//  Latency: frame_valid rises 2 cycles after the final byte (pixel or CHK) is accepted.
//  Read side: frame_valid = full[rd_sel]; rd_data registered from bank rd_sel; rd_addr>=NUM_PIXELS -> 0.
//   frame_release && frame_valid: full[rd_sel]=0, rd_sel^=1. Frames delivered strictly in arrival order.
//  Simultaneous COMMIT and release on different banks: both take effect same cycle.
//  err_clr and new error same cycle: error wins (flag set).
//  pix_cnt is ADDR_W bits, reset to 0 on every entry to PIX; never wraps within a frame.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: frame ends with CHK byte = 8-bit sum (mod 256) of MODE, LABEL (if
//   present) and all pixels. Match -> COMMIT; mismatch -> set err[1], bank not marked full, -> IDLE.
//  LOADER_CHECKSUM_EN undefined: no CHK state; PIX goes directly to COMMIT; err_flags[1] tied 0.
// STRUCTURE
//  Shared package cnn_pkg: NUM_PIXELS, SYNC_BYTE, MODE_INFER/MODE_TRAIN codes, loader FSM state
//   encoding, PIX_W=8.
//  One sub-module: pixel_bank_ram: 1W/1R synchronous RAM, depth 2*2**ADDR_W, addr {bank,idx},
//   registered read; bank meta (mode, label) held in flops in usb_image_loader.
// TESTING
//  1 Infer frame: A5,00, pixels p[i]=i[7:0] -> frame_valid, mode=0, label=0; rd_addr=300 -> rd_data=8'h2C next cycle.
//  2 Train frame: A5,01,07,784 px -> mode=1, label=7; label byte 0x0C instead -> err_flags=2'b01, no frame.
//  3 Three back-to-back frames, no release -> 2 frames held, accept low at 3rd SYNC; release -> 3rd accepted, order kept.
//  4 Garbage 00,FF,13 before A5 -> dropped, frame still assembled; MODE=02 -> err[0]=1, IDLE.
//  5 rst=0 after 400 pixels -> frame_valid=0, accept=1, fresh frame completes normally.
//  6 LOADER_CHECKSUM_EN: correct CHK -> frame_valid; CHK+1 -> err_flags=2'b10, no frame; err_clr -> 2'b00.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and loader state encoding for the CNN front end.
package cnn_pkg;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned PIX_W      = 8;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] MODE_INFER = 8'h00;
  localparam logic [7:0] MODE_TRAIN = 8'h01;
  localparam logic [7:0] MAX_LABEL  = 8'd9;

  typedef enum logic [2:0] {
    StIdle,
    StMode,
    StLabel,
    StPix,
    StChk,
    StCommit
  } loader_state_e;

endpackage

// File: rtl/pixel_bank_ram.sv
// Two-bank pixel store: one synchronous write port, one registered read port.
module pixel_bank_ram
  import cnn_pkg::*;
#(
  parameter int unsigned AddrW = 11
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [2**AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/usb_image_loader.sv
// Frames USB bytes into ping-pong buffered 28x28 images with a registered pixel read port.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module usb_image_loader
  import cnn_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        usb_data_in,
  input  logic              usb_data_valid,
  output logic              usb_data_accept,
  output logic              frame_valid,
  output logic              frame_mode_train,
  output logic [3:0]        frame_label,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              frame_release,
  output logic [1:0]        err_flags,
  input  logic              err_clr
);

  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0] PixLimit = ADDR_W'(NUM_PIXELS);

  loader_state_e     state_q;
  logic [1:0]        full_q;
  logic              wr_sel_q, rd_sel_q;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic              mode_q;
  logic [3:0]        label_q;
  logic [1:0]        meta_mode_q;
  logic [3:0]        meta_label_q [2];
  logic              err_hdr_q;
  logic              oob_q;
  logic [PIX_W-1:0]  ram_rdata;
  logic              xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
  logic              err_chk_q;
`endif

  assign xfer = usb_data_valid && usb_data_accept;

  always_comb begin
    usb_data_accept = 1'b1;
    case (state_q)
      StIdle:   usb_data_accept = !full_q[wr_sel_q];
      StCommit: usb_data_accept = 1'b0;
      default:  usb_data_accept = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      full_q       <= '0;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      pix_cnt_q    <= '0;
      mode_q       <= 1'b0;
      label_q      <= '0;
      meta_mode_q  <= '0;
      meta_label_q <= '{default: '0};
      err_hdr_q    <= 1'b0;
      oob_q        <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
      err_chk_q    <= 1'b0;
`endif
    end else begin
      // Clear first so an error raised below in the same cycle takes precedence.
      if (err_clr) begin
        err_hdr_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        err_chk_q <= 1'b0;
`endif
      end

      if (frame_release && full_q[rd_sel_q]) begin
        full_q[rd_sel_q] <= 1'b0;
        rd_sel_q         <= !rd_sel_q;
      end

      oob_q <= (rd_addr >= PixLimit);

      case (state_q)
        StIdle: begin
          if (xfer && usb_data_in == SYNC_BYTE) state_q <= StMode;
        end
        StMode: begin
          if (xfer) begin
            pix_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= usb_data_in;
`endif
            if (usb_data_in == MODE_INFER) begin
              mode_q  <= 1'b0;
              label_q <= '0;
              state_q <= StPix;
            end else if (usb_data_in == MODE_TRAIN) begin
              mode_q  <= 1'b1;
              state_q <= StLabel;
            end else begin
              err_hdr_q <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
        StLabel: begin
          if (xfer) begin
            pix_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= sum_q + usb_data_in;
`endif
            if (usb_data_in <= MAX_LABEL) begin
              label_q <= usb_data_in[3:0];
              state_q <= StPix;
            end else begin
              err_hdr_q <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
        StPix: begin
          if (xfer) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= sum_q + usb_data_in;
            if (pix_cnt_q == LastIdx) state_q <= StChk;
`else
            if (pix_cnt_q == LastIdx) state_q <= StCommit;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StChk: begin
          if (xfer) begin
            if (usb_data_in == sum_q) begin
              state_q <= StCommit;
            end else begin
              err_chk_q <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
`endif
        StCommit: begin
          full_q[wr_sel_q]       <= 1'b1;
          meta_mode_q[wr_sel_q]  <= mode_q;
          meta_label_q[wr_sel_q] <= label_q;
          wr_sel_q               <= !wr_sel_q;
          state_q                <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pixel_bank_ram #(
    .AddrW(ADDR_W + 1)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (xfer && state_q == StPix),
    .waddr_i({wr_sel_q, pix_cnt_q}),
    .wdata_i(usb_data_in),
    .raddr_i({rd_sel_q, rd_addr}),
    .rdata_o(ram_rdata)
  );

  assign frame_valid      = full_q[rd_sel_q];
  assign frame_mode_train = meta_mode_q[rd_sel_q];
  assign frame_label      = meta_label_q[rd_sel_q];
  assign rd_data          = oob_q ? 8'h00 : ram_rdata;

`ifdef LOADER_CHECKSUM_EN
  assign err_flags = {err_chk_q, err_hdr_q};
`else
  assign err_flags = {1'b0, err_hdr_q};
`endif

endmodule

// File: tb/tb_usb_image_loader.sv
// Scoreboard bench for usb_image_loader: stimulus queues expected frames, monitor drains them.
module tb_usb_image_loader;

  localparam int NPIX = 784;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] usb_data_in = 8'h00;
  logic       usb_data_valid = 1'b0;
  logic       usb_data_accept;
  logic       frame_valid;
  logic       frame_mode_train;
  logic [3:0] frame_label;
  logic [9:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       frame_release = 1'b0;
  logic [1:0] err_flags;
  logic       err_clr = 1'b0;

  always #5 clk = ~clk;

  usb_image_loader dut (
    .clk             (clk),
    .rst             (rst),
    .usb_data_in     (usb_data_in),
    .usb_data_valid  (usb_data_valid),
    .usb_data_accept (usb_data_accept),
    .frame_valid     (frame_valid),
    .frame_mode_train(frame_mode_train),
    .frame_label     (frame_label),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .frame_release   (frame_release),
    .err_flags       (err_flags),
    .err_clr         (err_clr)
  );

  typedef struct {
    bit         train;
    int         label;
    logic [7:0] px [NPIX];
  } frame_t;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  bit     hold = 1'b0;
  bit     mon_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t make_frame(input bit train, input int label, input bit ramp);
    frame_t f;
    f.train = train;
    f.label = train ? label : 0;
    for (int i = 0; i < NPIX; i++) f.px[i] = ramp ? i[7:0] : 8'($urandom);
    return f;
  endfunction

  // Drive one byte after `gap` idle cycles and wait (bounded) until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    usb_data_in    = b;
    usb_data_valid = 1'b1;
    for (n = 0; n < 3000; n++) begin
      if (usb_data_accept) break;
      @(negedge clk);
    end
    if (n == 3000) check("accept_timeout", 0, 1);
    @(negedge clk);
    usb_data_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int gap_max, input bit push, input bit bad_chk);
    logic [7:0] sum;
    if (push) exp_q.push_back(f);
    sum = f.train ? 8'h01 : 8'h00;
    send_byte(8'hA5, $urandom_range(0, gap_max));
    send_byte(sum, $urandom_range(0, gap_max));
    if (f.train) begin
      send_byte(8'(f.label), $urandom_range(0, gap_max));
      sum = sum + 8'(f.label);
    end
    for (int i = 0; i < NPIX; i++) begin
      send_byte(f.px[i], $urandom_range(0, gap_max));
      sum = sum + f.px[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_chk ? sum + 8'h01 : sum, $urandom_range(0, gap_max));
`else
    if (bad_chk) sum = 8'h00;
`endif
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy && !frame_valid) break;
    end
    if (n == 5000) check("drain_timeout", 0, 1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Monitor: compare each readable frame against the oldest expected one, then release it.
  initial begin
    frame_t f;
    int     addrs [7];
    forever begin
      @(negedge clk);
      if (rst && !hold && frame_valid) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          f = exp_q.pop_front();
          check("frame_mode", int'(frame_mode_train), int'(f.train));
          check("frame_label", int'(frame_label), f.label);
          addrs = '{0, 300, NPIX - 1, $urandom_range(0, NPIX - 1),
                    $urandom_range(0, NPIX - 1), NPIX, 1023};
          rd_addr = 10'(addrs[0]);
          for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("rd_data[%0d]", addrs[i]), int'(rd_data),
                  addrs[i] < NPIX ? int'(f.px[addrs[i]]) : 0);
            if (i < 6) rd_addr = 10'(addrs[i + 1]);
          end
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        frame_release = 1'b1;
        @(negedge clk);
        frame_release = 1'b0;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    repeat (3) @(negedge clk);
    check("rst_frame_valid", int'(frame_valid), 0);
    check("rst_accept", int'(usb_data_accept), 1);
    check("rst_err", int'(err_flags), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_mode", int'(frame_mode_train), 0);
    check("rst_label", int'(frame_label), 0);
    rst = 1'b1;

    // Inference ramp frame with back-to-back bytes, plus the commit latency.
    f = make_frame(1'b0, 0, 1'b1);
    send_frame(f, 0, 1'b1, 1'b0);
    check("latency_cycle1", int'(frame_valid), 0);
    @(negedge clk);
    check("latency_cycle2", int'(frame_valid), 1);
    wait_idle();

    f = make_frame(1'b1, 7, 1'b0);
    send_frame(f, 1, 1'b1, 1'b0);
    wait_idle();

    // Out-of-range label is flagged and the frame is dropped.
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h0C, 0);
    repeat (2) @(negedge clk);
    check("bad_label_err", int'(err_flags), 1);
    check("bad_label_noframe", int'(frame_valid), 0);
    pulse_clr();
    check("err_cleared", int'(err_flags), 0);

    // Leading garbage is dropped, then an unknown MODE raised while err_clr is held.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h13, 0);
    f = make_frame(1'b1, 3, 1'b0);
    send_frame(f, 0, 1'b1, 1'b0);
    wait_idle();
    send_byte(8'hA5, 0);
    err_clr = 1'b1;
    send_byte(8'h02, 0);
    err_clr = 1'b0;
    @(negedge clk);
    check("bad_mode_err_wins", int'(err_flags), 1);
    pulse_clr();

    // Backpressure: both banks full holds off the third frame without loss.
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      f = make_frame(k[0], k + 4, 1'b0);
      send_frame(f, 0, 1'b1, 1'b0);
    end
    repeat (3) @(negedge clk);
    check("both_full_accept", int'(usb_data_accept), 0);
    check("both_full_valid", int'(frame_valid), 1);
    f = make_frame(1'b1, 9, 1'b0);
    fork
      send_frame(f, 0, 1'b1, 1'b0);
      begin
        repeat (20) @(negedge clk);
        check("held_accept", int'(usb_data_accept), 0);
        hold = 1'b0;
      end
    join
    wait_idle();

    // Reset in the middle of a frame discards it.
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 400; i++) send_byte(8'($urandom), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(frame_valid), 0);
    check("midrst_accept", int'(usb_data_accept), 1);
    rst = 1'b1;
    f = make_frame(1'b0, 0, 1'b0);
    send_frame(f, 0, 1'b1, 1'b0);
    wait_idle();

`ifdef LOADER_CHECKSUM_EN
    f = make_frame(1'b1, 2, 1'b0);
    send_frame(f, 0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("bad_chk_err", int'(err_flags), 2);
    check("bad_chk_noframe", int'(frame_valid), 0);
    pulse_clr();
    check("chk_err_cleared", int'(err_flags), 0);
`endif

    // Randomised frames with random byte gaps and release delays.
    for (int k = 0; k < 10; k++) begin
      f = make_frame(1'($urandom), $urandom_range(0, 9), 1'b0);
      send_frame(f, 2, 1'b1, 1'b0);
    end
    wait_idle();
    check("err_idle_end", int'(err_flags), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
